// File: rtl/display_sched_pkg.sv
// ---------------------------------------------------------------------------
// display_sched_pkg
//   Shared types and constants for the display scheduler slice.
//   - digit_t      : one BCD/hex digit as driven to the seven-segment mux
//   - scan_idx_t   : index of the digit currently being scanned (0..3)
//   - req_id_t     : identifies one of the two update requesters
//   - BLANK_CODE   : digit code that the BCD decoder renders as all-off
//   - TICK_DIV_DEFAULT : clk cycles per scan tick (100 MHz / 500 Hz)
//   - blank_leading_zeros() : replaces leading zero digits with BLANK_CODE
// ---------------------------------------------------------------------------
package display_sched_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] scan_idx_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    localparam digit_t BLANK_CODE       = 4'hF;
    localparam int     TICK_DIV_DEFAULT = 200000;

    // Walks from digit3 down to digit1; every zero seen before the first
    // nonzero digit is blanked. digit0 is never examined, so a value of
    // zero still shows a single '0'.
    function automatic logic [15:0] blank_leading_zeros(input logic [15:0] raw);
        logic [15:0] res;
        logic        leading;
        res     = raw;
        leading = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (leading && (raw[i*4 +: 4] == 4'h0)) begin
                res[i*4 +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// ---------------------------------------------------------------------------
// scan_divider
//   Free-running modulo-TICK_DIV counter that emits a one-cycle scan tick.
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   synchronous active-high reset (counter to 0)
//     scan_tick out  high in the cycle the count equals TICK_DIV-1
//   Parameters:
//     TICK_DIV  clk cycles per tick, must be >= 2
// ---------------------------------------------------------------------------
module scan_divider
    import display_sched_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic scan_tick
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Tick is decoded from the registered count, so it is clean and is
    // naturally low while the counter sits at 0 after reset.
    always_comb begin
        scan_tick = (count_q == CNT_LAST);
        count_d   = scan_tick ? '0 : count_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of all other flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
//   Scan pacing, digit index tracking and round-robin arbitration of digit
//   updates for a four-digit seven-segment multiplexer. Accepted updates sit
//   in a shadow buffer and are committed only at the end of a frame, so the
//   display never shows a mix of old and new digits.
//
//   Ports:
//     clk, rst                 clock and synchronous active-high reset
//     req0_valid/data/ready    requester 0 (data[3:0] is digit0 ... [15:12] digit3)
//     req1_valid/data/ready    requester 1, same layout
//     digit0..digit3           committed digits to the multiplexer
//     scan_tick                one-cycle pulse every TICK_DIV cycles
//     scan_idx                 digit currently being scanned
//     frame_end                scan_tick while scanning digit 3
//     pending                  shadow buffer holds an uncommitted update
//
//   Optional feature (compile-time macro):
//     BLANK_LEADING_ZEROS_EN   blank leading zero digits at commit time;
//                              the shadow buffer keeps the raw value.
// ---------------------------------------------------------------------------
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,

    output logic [3:0]  digit0,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,

    output logic        scan_tick,
    output logic [1:0]  scan_idx,
    output logic        frame_end,
    output logic        pending
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_idx_t   scan_idx_q, scan_idx_d;
    logic [15:0] digits_q,   digits_d;
    logic [15:0] shadow_q,   shadow_d;
    logic        pending_q,  pending_d;
    req_id_t     last_q,     last_d;

    logic        grant0;
    logic        grant1;
    logic        can_accept;
    logic [15:0] commit_value;

    // ------------------------------------------------------------------
    // Scan tick generation
    // ------------------------------------------------------------------
    scan_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_scan_divider (
        .clk       (clk),
        .rst       (rst),
        .scan_tick (scan_tick)
    );

    assign frame_end = scan_tick && (scan_idx_q == scan_idx_t'(3));

    // ------------------------------------------------------------------
    // Round-robin arbitration
    //   Nothing is accepted while an update is still waiting to commit or
    //   in the commit cycle itself, which bounds throughput to one update
    //   per frame and keeps transfer and commit from ever colliding.
    // ------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch appears.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        can_accept = !rst && !pending_q && !frame_end;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                // Contention: the requester that did not win last time goes.
                if (last_q == REQ1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ------------------------------------------------------------------
    // Value presented at commit
    // ------------------------------------------------------------------
`ifdef BLANK_LEADING_ZEROS_EN
    assign commit_value = blank_leading_zeros(shadow_q);
`else
    assign commit_value = shadow_q;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        scan_idx_d = scan_idx_q;
        digits_d   = digits_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        last_d     = last_q;

        // Two-bit index wraps 3 -> 0 on its own.
        if (scan_tick) begin
            scan_idx_d = scan_idx_q + scan_idx_t'(1);
        end

        if (frame_end && pending_q) begin
            digits_d  = commit_value;
            pending_d = 1'b0;
        end else if (grant0) begin
            shadow_d  = req0_data;
            pending_d = 1'b1;
            last_d    = REQ0;
        end else if (grant1) begin
            shadow_d  = req1_data;
            pending_d = 1'b1;
            last_d    = REQ1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    //   last resets to REQ1 so requester 0 wins the first contention.
    //   Clearing pending and shadow on reset drops any update in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_q <= '0;
            digits_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            last_q     <= REQ1;
        end else begin
            scan_idx_q <= scan_idx_d;
            digits_q   <= digits_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            last_q     <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign digit0   = digits_q[3:0];
    assign digit1   = digits_q[7:4];
    assign digit2   = digits_q[11:8];
    assign digit3   = digits_q[15:12];
    assign scan_idx = scan_idx_q;
    assign pending  = pending_q;

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Controller for the four-digit seven-segment multiplexer. It generates the digit-scan tick, tracks which digit is being scanned, and arbitrates digit-update requests from two requesters using a round-robin valid/ready scheme. Each accepted update is held in a shadow buffer and committed only at a frame boundary, so the display never shows a mix of old and new digits. Its `digit0..3` outputs drive the multiplexer's digit inputs, and `scan_tick` paces the multiplexer's state advance.

## Interface
- `TICK_DIV`, default 200000: clk cycles per scan tick (100 MHz / 500 Hz); must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an update.
- `req0_data`  in  16  requester 0 digits: [3:0] is digit0 … [15:12] is digit3.
- `req0_ready`  out  1  requester 0 is granted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `digit0`..`digit3`  out  4 each  committed digits to the multiplexer.
- `scan_tick`  out  1  one-cycle pulse every `TICK_DIV` cycles.
- `scan_idx`  out  2  index of the digit currently being scanned.
- `frame_end`  out  1  equals `scan_tick` AND `scan_idx == 3`.
- `pending`  out  1  the shadow buffer holds an uncommitted update.

## Operation
- **Divider**
  - Counts 0 to `TICK_DIV-1`, then wraps.
  - `scan_tick` is asserted in the cycle the count equals `TICK_DIV-1`.
- **Scan index**
  - `scan_idx` increments on each `scan_tick`: 3 wraps to 0.
- **Readiness**
  - `req*_ready` is asserted only when `pending == 0` and `frame_end == 0`.
- **Arbitration**
  - Round-robin; a `last` pointer records the most recently granted requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than `last` is granted.
  - At most one ready is asserted per cycle.
  - Ready is combinational from the valids, `pending` and `last`.
- **Handshake**
  - A transfer occurs when valid and ready are both high.
  - On transfer: shadow ← data, `pending` ← 1, `last` ← the granted requester.
  - A requester must hold valid and data stable until it is granted.
  - A non-granted requester keeps waiting; its request is never dropped.
- **Commit**
  - On `frame_end` with `pending == 1`: `digit0..3` ← shadow, `pending` ← 0.
  - On `frame_end` with `pending == 0`: no change.
- **Digit values**
  - Values 10 to 15 pass through unchanged.
  - No arithmetic is performed on digit values.
- **Reset**
  - `digit0..3` = 0, `scan_idx` = 0, divider = 0, `scan_tick` = 0, `frame_end` = 0.
  - `pending` = 0; the shadow buffer is cleared.
  - `last` = 1, so requester 0 wins the first contention.
  - Ready outputs are 0 while `rst` is high.
  - Reset during an operation discards any pending update; no partial commit occurs.

## Timing
- Accept latency: `req_ready` rises in the same cycle as `req_valid` when the buffer is free.
- Commit latency: the digits update in the cycle after the next `frame_end` edge. Worst case is 4·`TICK_DIV` cycles after acceptance.
- Simultaneous commit and request: no grant in the `frame_end` cycle; the grant occurs in the following cycle.
- Throughput: at most one update per frame.
- `scan_idx` and `digit*` change only on clock edges and are registered.

## Configuration
- `BLANK_LEADING_ZEROS_EN`, when defined:
  - At commit, zero digits are replaced by `BLANK_CODE`, scanning from digit3 downward and stopping at the first nonzero digit.
  - digit0 is never blanked.
  - The shadow buffer keeps the raw values.
- When undefined, the raw digits are committed unchanged.

## Structure
- Package `display_sched_pkg` holds:
  - `BLANK_CODE = 4'hF` (the BCD decoder renders it as all segments off);
  - `typedef logic [3:0] digit_t`;
  - `typedef logic [1:0] scan_idx_t`;
  - the default value of `TICK_DIV`.
- Sub-module `scan_divider` (`TICK_DIV` counter producing `scan_tick`) is natural. Arbitration, shadow buffer and commit stay in the top module.

## Test plan
Bench uses `TICK_DIV = 4`.
- **Reset:** assert `rst` for 2 cycles, then release → all digits 0, `scan_idx` 0, and the first `scan_tick` on the 4th cycle after release; `frame_end` every 16 cycles.
- **Single request:** `req0_valid` with data 16'h1234 → `req0_ready` the same cycle, `pending` = 1, digits 4/3/2/1 after the next `frame_end`, `pending` = 0.
- **Contention:** both valid, 16'hAAAA on req0 and 16'h5555 on req1, from reset → req0 granted first. Keeping both asserted, req1 is granted in the first cycle after the commit; req0 is not granted before req1.
- **Request in the `frame_end` cycle:** `req1_valid` rises in that cycle → `req1_ready` = 0 then, 1 in the next cycle.
- **Reset mid-operation:** accept 16'h9999, assert `rst` before `frame_end` → digits stay 0 and `pending` = 0.
- **`BLANK_LEADING_ZEROS_EN`:** commit 16'h0070 → digit3 = F, digit2 = F, digit1 = 7, digit0 = 0.
